// File: rtl/tff_bank_ctrl.sv
// Sequencing controller for a bank of external toggle flip-flops: clears, loads
// and counts the bank through its T inputs, then verifies the read-back against a shadow.
module tff_bank_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_ARG,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic             BUSY,
  output logic             DONE,
  output logic             MISMATCH,
  output logic             WRAP
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_APPLY,
    S_COUNT,
    S_CHECK
  } state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] arg_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             done_reg;
  logic             mismatch_reg;
  logic             wrap_reg;

  // Prefix ANDs of Q and ~Q give the ripple-carry toggle pattern for up/down counting.
  logic [WIDTH:0]   ones_pre;
  logic [WIDTH:0]   zeros_pre;
  logic [WIDTH-1:0] step_t;
  logic [WIDTH-1:0] target;
  logic             count_wrap;

  assign ones_pre[0]  = 1'b1;
  assign zeros_pre[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
      assign ones_pre[gi+1]  = ones_pre[gi] & Q[gi];
      assign zeros_pre[gi+1] = zeros_pre[gi] & ~Q[gi];
    end
  endgenerate

  assign step_t     = (op_reg == OP_DOWN) ? zeros_pre[WIDTH-1:0] : ones_pre[WIDTH-1:0];
  assign count_wrap = (op_reg == OP_DOWN) ? zeros_pre[WIDTH] : ones_pre[WIDTH];
  assign target     = (op_reg == OP_LOAD) ? arg_reg : '0;

  // T has no register stage: the bank toggles on the edge that ends this cycle.
  always_comb begin
    T = '0;
    if (!RST) begin
      case (state_reg)
        S_INIT:  T = Q;
        S_APPLY: T = Q ^ target;
        S_COUNT: T = step_t;
        default: T = '0;
      endcase
    end
  end

  assign CMD_READY = !RST && (state_reg == S_IDLE);
  assign BUSY      = RST || (state_reg != S_IDLE);
  assign DONE      = done_reg && !RST;
  assign MISMATCH  = mismatch_reg && !RST;
  assign WRAP      = wrap_reg && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_INIT;
      op_reg       <= OP_CLEAR;
      arg_reg      <= '0;
      shadow_reg   <= '0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      mismatch_reg <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_INIT: state_reg <= S_IDLE;
        S_IDLE: begin
          if (CMD_VALID) begin
            op_reg       <= CMD_OP;
            arg_reg      <= CMD_ARG;
            mismatch_reg <= 1'b0;
            wrap_reg     <= 1'b0;
            case (CMD_OP)
              OP_CLEAR: shadow_reg <= '0;
              OP_LOAD:  shadow_reg <= CMD_ARG;
              OP_UP:    shadow_reg <= shadow_reg + CMD_ARG;
              default:  shadow_reg <= shadow_reg - CMD_ARG;
            endcase
            if (!CMD_OP[1]) begin
              state_reg <= S_APPLY;
            end else if (CMD_ARG == '0) begin
              state_reg <= S_CHECK;
            end else begin
              cnt_reg   <= CMD_ARG;
              state_reg <= S_COUNT;
            end
          end
        end
        S_APPLY: state_reg <= S_CHECK;
        S_COUNT: begin
          cnt_reg <= cnt_reg - WIDTH'(1);
          if (count_wrap) wrap_reg <= 1'b1;
          if (cnt_reg == WIDTH'(1)) state_reg <= S_CHECK;
        end
        S_CHECK: begin
          // Resync to the real bank so a stuck bit is reported once, not forever.
          mismatch_reg <= (Q != shadow_reg);
          shadow_reg   <= Q;
          done_reg     <= 1'b1;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Bench for tff_bank_ctrl with a 4-bit TFF bank model; expected DONE results are
// queued at command issue and compared by an independent monitor.
module tb_tff_bank_ctrl;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         CMD_VALID;
  logic         CMD_READY;
  logic [1:0]   CMD_OP;
  logic [W-1:0] CMD_ARG;
  logic [W-1:0] Q;
  logic [W-1:0] T;
  logic         BUSY;
  logic         DONE;
  logic         MISMATCH;
  logic         WRAP;

  logic [W-1:0] bank;
  logic [W-1:0] stuck0;
  logic [W-1:0] preset_val;
  logic         preset_en;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    int           cyc;
    logic         m;
    logic         w;
    logic [W-1:0] q;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 CLK = ~CLK;

  tff_bank_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG), .Q(Q), .T(T), .BUSY(BUSY),
    .DONE(DONE), .MISMATCH(MISMATCH), .WRAP(WRAP)
  );

  // Bank of toggle flip-flops; stuck0 forces selected bits to 0.
  assign Q = bank;
  always @(posedge CLK) begin
    if (preset_en) bank <= preset_val;
    else           bank <= (bank ^ T) & ~stuck0;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, input bit expect_done,
                       input int lat, input logic m, input logic w, input logic [W-1:0] q);
    int   n;
    exp_t e;
    n = 0;
    while (!CMD_READY && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_issue", CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_ARG   = arg;
    e.cyc = cyc + lat;
    e.m   = m;
    e.w   = w;
    e.q   = q;
    if (expect_done) sb.push_back(e);
    $display("issue op=%0d arg=%b cycle=%0d expect q=%b mism=%0b wrap=%0b", op, arg, cyc, q, m, w);
    tick();
    CMD_VALID = 1'b0;
    CMD_OP    = ~op;
    CMD_ARG   = ~arg;
    chk("accepted", CMD_READY, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", DONE, 1);
  endtask

  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", DONE, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("done_mismatch", MISMATCH, mon_e.m);
        chk("done_wrap", WRAP, mon_e.w);
        chk("done_q", Q, mon_e.q);
        $display("done cycle=%0d q=%b mism=%0b wrap=%0b", cyc, Q, MISMATCH, WRAP);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] up_seq [5];
    up_seq = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};

    // Reset with bank preset to 1011, then INIT clears it.
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_ARG = '0;
    stuck0 = '0; preset_en = 1'b1; preset_val = 4'b1011;
    tick();
    preset_en = 1'b0;
    chk("rst_T", T, 4'b0000);
    chk("rst_ready", CMD_READY, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    #1;
    chk("init_T", T, 4'b1011);
    chk("init_ready", CMD_READY, 0);
    tick();
    chk("init_clear_q", Q, 4'b0000);
    chk("ready_after_init", CMD_READY, 1);

    // LOAD 0110 from 0000.
    issue(2'b01, 4'b0110, 1, 3, 1'b0, 1'b0, 4'b0110);
    chk("apply_T", T, 4'b0110);
    wait_done();

    // COUNT_UP 5 from 1101 wraps through 1111.
    issue(2'b01, 4'b1101, 1, 3, 1'b0, 1'b0, 4'b1101);
    wait_done();
    issue(2'b10, 4'd5, 1, 7, 1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("up_seq_q", Q, up_seq[i]);
    end
    wait_done();

    // COUNT_DOWN 0 from 0011, then CLEAR issued in the DONE cycle.
    issue(2'b01, 4'b0011, 1, 3, 1'b0, 1'b0, 4'b0011);
    wait_done();
    issue(2'b11, 4'd0, 1, 2, 1'b0, 1'b0, 4'b0011);
    chk("down0_T", T, 4'b0000);
    chk("down0_q", Q, 4'b0011);
    wait_done();
    issue(2'b00, 4'b1010, 1, 3, 1'b0, 1'b0, 4'b0000);
    wait_done();

    // Stuck bit 2 during LOAD 1111; shadow resyncs to 1011, so UP 1 expects 1100.
    stuck0 = 4'b0100;
    issue(2'b01, 4'b1111, 1, 3, 1'b1, 1'b0, 4'b1011);
    wait_done();
    stuck0 = 4'b0000;
    tick();
    chk("mism_hold", MISMATCH, 1);
    issue(2'b10, 4'd1, 1, 3, 1'b0, 1'b0, 4'b1100);
    chk("mism_cleared", MISMATCH, 0);
    wait_done();

    // Reset on the 2nd cycle of COUNT_UP 8 from 1100 aborts without DONE.
    issue(2'b10, 4'd8, 0, 10, 1'b0, 1'b0, 4'b0100);
    tick();
    chk("abort_q_before", Q, 4'b1101);
    RST = 1'b1;
    #1;
    chk("abort_T", T, 4'b0000);
    chk("abort_busy", BUSY, 1);
    chk("abort_ready", CMD_READY, 0);
    tick();
    chk("abort_hold_q", Q, 4'b1101);
    RST = 1'b0;
    #1;
    chk("abort_init_T", T, 4'b1101);
    tick();
    chk("abort_clear_q", Q, 4'b0000);
    chk("abort_wrap", WRAP, 0);
    chk("abort_mism", MISMATCH, 0);
    chk("abort_ready_idle", CMD_READY, 1);
    repeat (12) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
